seq_1001_tx: RTL



---
 rtl/seq_1001_pkg.sv | 22 ++
 rtl/seq_1001_tx_piso_shreg.sv | 40 ++++
 rtl/seq_1001_tx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/seq_1001_pkg.sv
// seq_1001_pkg: definitions shared by the 1001 link transmitter and detector.
//   state_e          : transmitter FSM state encoding (2 bits, observable on state_out)
//   MARKER_DEFAULT   : default sync marker, sent MSB-first
//   MARKER_W_DEFAULT : default marker width in bits
//   max_u            : elaboration-time maximum helper for sizing counters
package seq_1001_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMark = 2'd1,
        StData = 2'd2,
        StPar  = 2'd3
    } state_e;

    localparam logic [3:0]  MARKER_DEFAULT   = 4'b1001;
    localparam int unsigned MARKER_W_DEFAULT = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_1001_tx_piso_shreg.sv
// piso_shreg: parallel-in serial-out shift register, MSB-first.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset, clears the register
//   load_en  in  load par_in (takes priority over shift_en)
//   shift_en in  shift left by one, zero fill
//   par_in   in  parallel word [WIDTH]
//   ser_out  out current MSB
module piso_shreg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out
);

    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_en) begin
            sr_d = par_in;
        end else if (shift_en) begin
            sr_d = sr_q << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign ser_out = sr_q[WIDTH-1];

endmodule

// File: rtl/seq_1001_tx.sv
// seq_1001_tx: serial frame transmitter for the 1001 sequence-detector link.
// A payload word accepted on a valid/ready handshake is sent one bit per clock as
// MARKER (MSB-first), then the payload (MSB-first), then optionally an even parity bit.
// Optional feature macro: SEQ_1001_TX_PARITY_EN (adds the parity bit / PAR state).
//   clk       in  system clock, rising edge
//   rst_n     in  asynchronous active-low reset
//   in_valid  in  payload word offered
//   in_data   in  payload word [DATA_W]
//   in_ready  out block can accept a word (IDLE only)
//   tx_bit    out serial output bit, registered; low when idle
//   tx_active out a frame bit is on tx_bit
//   tx_last   out tx_bit holds the final frame bit
//   state_out out current FSM state
module seq_1001_tx
    import seq_1001_pkg::*;
#(
    parameter int unsigned            DATA_W   = 8,
    parameter int unsigned            MARKER_W = MARKER_W_DEFAULT,
    parameter logic [MARKER_W-1:0]    MARKER   = MARKER_W'(MARKER_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_active,
    output logic              tx_last,
    output logic [1:0]        state_out
);

    localparam int unsigned     CNT_W     = $clog2(max_u(MARKER_W, DATA_W) + 1);
    localparam logic [CNT_W-1:0] MARK_LAST = CNT_W'(MARKER_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_bit_q, tx_bit_d;
    logic             sr_load, sr_shift, sr_msb;
    logic [MARKER_W-1:0] mark_next;

`ifdef SEQ_1001_TX_PARITY_EN
    logic par_q, par_d;
`endif

    piso_shreg #(
        .WIDTH (DATA_W)
    ) u_payload (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (sr_load),
        .shift_en (sr_shift),
        .par_in   (in_data),
        .ser_out  (sr_msb)
    );

    // Marker bit (cnt_q + 1) from the MSB lands in the top position.
    assign mark_next = MARKER << (cnt_q + 1'b1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tx_bit_d = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
`ifdef SEQ_1001_TX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d  = StMark;
                    cnt_d    = '0;
                    tx_bit_d = MARKER[MARKER_W-1];
                    sr_load  = 1'b1;
`ifdef SEQ_1001_TX_PARITY_EN
                    par_d    = ^in_data;
`endif
                end
            end
            StMark: begin
                if (cnt_q == MARK_LAST) begin
                    // Payload MSB goes out next; consume it from the shift register.
                    state_d  = StData;
                    cnt_d    = '0;
                    tx_bit_d = sr_msb;
                    sr_shift = 1'b1;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    tx_bit_d = mark_next[MARKER_W-1];
                end
            end
            StData: begin
                if (cnt_q == DATA_LAST) begin
                    cnt_d    = '0;
`ifdef SEQ_1001_TX_PARITY_EN
                    state_d  = StPar;
                    tx_bit_d = par_q;
`else
                    state_d  = StIdle;
`endif
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    tx_bit_d = sr_msb;
                    sr_shift = 1'b1;
                end
            end
`ifdef SEQ_1001_TX_PARITY_EN
            StPar: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
`endif
            default: begin
                // Reserved encoding (PAR without parity) recovers to IDLE.
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            tx_bit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tx_bit_q <= tx_bit_d;
        end
    end

`ifdef SEQ_1001_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign tx_last = (state_q == StPar);
`else
    assign tx_last = (state_q == StData) && (cnt_q == DATA_LAST);
`endif

    assign in_ready  = (state_q == StIdle);
    assign tx_active = (state_q != StIdle);
    assign tx_bit    = tx_bit_q;
    assign state_out = state_q;

endmodule
